// File: rtl/keylimepi_uart_pkg.sv
// Shared constants and enums for the UART frame decoder.
package keylimepi_uart_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CHK     = 2'b01,
    ERR_LEN     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } dec_state_e;

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte idle timer: counts while enabled, strobes expired on the last count.
module uart_timeout_timer #(
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A clear in the same cycle (incoming byte) always beats expiry.
  assign o_expired = i_enable && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes SOF/CMD/LEN/payload/CHK frames from a byte stream and holds them for a consumer.
module uart_frame_decoder
  import keylimepi_uart_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 100000,
  localparam int unsigned AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  output logic          frame_ready,
  input  logic          frame_ack,
  output logic [7:0]    frame_cmd,
  output logic [7:0]    frame_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_valid,
  output logic [1:0]    err_code,
  output logic          overrun
);

  dec_state_e r_state;
  err_code_e  r_err_code;
  logic [7:0] r_cmd;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_xor;
  logic [7:0] r_frame_cmd;
  logic [7:0] r_frame_len;
  logic       r_frame_ready;
  logic       r_err_valid;
  logic       r_overrun;
  logic [7:0] r_buf [MAX_LEN];

  logic w_active;
  logic w_expired;
  logic w_buf_we;

  assign w_active = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                    (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
  assign w_buf_we = rx_valid && (r_state == ST_PAYLOAD);

  uart_timeout_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (rx_valid),
    .i_enable (w_active),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_idx[AW-1:0]] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_err_code    <= ERR_NONE;
      r_cmd         <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_xor         <= '0;
      r_frame_cmd   <= '0;
      r_frame_len   <= '0;
      r_frame_ready <= 1'b0;
      r_err_valid   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_err_valid <= 1'b0;
      r_overrun   <= 1'b0;
      if (rx_valid) begin
        unique case (r_state)
          ST_IDLE: begin
            if (rx_byte == SOF) r_state <= ST_CMD;
          end
          ST_CMD: begin
            r_cmd   <= rx_byte;
            r_xor   <= rx_byte;
            r_state <= ST_LEN;
          end
          ST_LEN: begin
            r_len <= rx_byte;
            r_xor <= r_xor ^ rx_byte;
            r_idx <= '0;
            if (rx_byte == 8'd0) begin
              r_state <= ST_CHECK;
            end else if (rx_byte > 8'(MAX_LEN)) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_LEN;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            r_xor <= r_xor ^ rx_byte;
            r_idx <= r_idx + 8'd1;
            if (r_idx == r_len - 8'd1) r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (rx_byte == r_xor) begin
              r_frame_ready <= 1'b1;
              r_frame_cmd   <= r_cmd;
              r_frame_len   <= r_len;
              r_state       <= ST_HOLD;
            end else begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_CHK;
              r_state     <= ST_IDLE;
            end
          end
          ST_HOLD: begin
            // Release and a new byte together: the byte is handled as if already idle.
            if (frame_ack) begin
              r_frame_ready <= 1'b0;
              r_state       <= (rx_byte == SOF) ? ST_CMD : ST_IDLE;
            end else begin
              r_overrun <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state == ST_HOLD) begin
        if (frame_ack) begin
          r_frame_ready <= 1'b0;
          r_state       <= ST_IDLE;
        end
      end else if (w_expired) begin
        r_err_valid <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= ST_IDLE;
      end
    end
  end

  assign frame_ready = r_frame_ready;
  assign frame_cmd   = r_frame_cmd;
  assign frame_len   = r_frame_len;
  assign rd_data     = r_buf[rd_addr];
  assign err_valid   = r_err_valid;
  assign err_code    = r_err_code;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed self-checking bench for uart_frame_decoder (MAX_LEN=16, TIMEOUT_CLKS=50).
module tb_uart_frame_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = '0;
  logic       frame_ready;
  logic [7:0] frame_cmd;
  logic [7:0] frame_len;
  logic [7:0] rd_data;
  logic       err_valid;
  logic [1:0] err_code;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  uart_frame_decoder #(
    .MAX_LEN(16),
    .TIMEOUT_CLKS(50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_ready(frame_ready),
    .frame_ack  (frame_ack),
    .frame_cmd  (frame_cmd),
    .frame_len  (frame_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] b;
    logic       ack;
    logic [3:0] ra;
    logic       e_ready;
    logic       e_err;
    logic [1:0] e_code;
    logic       e_ovr;
    logic       chk_fr;
    logic [7:0] e_cmd;
    logic [7:0] e_len;
    logic       chk_rd;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tv [30];

  function automatic vec_t mk(input logic vld, input logic [7:0] b, input logic ack,
                              input logic [3:0] ra, input logic er, input logic ee,
                              input logic [1:0] ec, input logic eo, input logic cf,
                              input logic [7:0] ecmd, input logic [7:0] elen,
                              input logic cr, input logic [7:0] erd);
    vec_t v;
    v.vld = vld; v.b = b; v.ack = ack; v.ra = ra;
    v.e_ready = er; v.e_err = ee; v.e_code = ec; v.e_ovr = eo;
    v.chk_fr = cf; v.e_cmd = ecmd; v.e_len = elen; v.chk_rd = cr; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic vld, input logic [7:0] b, input logic ack);
    @(negedge clk);
    rx_valid  = vld;
    rx_byte   = b;
    frame_ack = ack;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    frame_ack = 1'b0;
  endtask

  logic [7:0] pl [16];
  logic [7:0] x;

  initial begin
    //            vld b     ack ra  rdy err code ovr cf  cmd    len   cr  rd
    tv[0]  = mk(1, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[1]  = mk(1, 8'h5A, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[2]  = mk(1, 8'hFF, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[3]  = mk(1, 8'hA5, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[4]  = mk(1, 8'h10, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[5]  = mk(1, 8'h03, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[6]  = mk(1, 8'h11, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[7]  = mk(1, 8'h22, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[8]  = mk(1, 8'h33, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[9]  = mk(1, 8'h13, 0, 0, 1, 0, 2'd0, 0, 1, 8'h10, 8'd3, 1, 8'h11);
    tv[10] = mk(0, 8'h00, 0, 1, 1, 0, 2'd0, 0, 1, 8'h10, 8'd3, 1, 8'h22);
    tv[11] = mk(1, 8'h55, 0, 2, 1, 0, 2'd0, 1, 1, 8'h10, 8'd3, 1, 8'h33);
    tv[12] = mk(0, 8'h00, 0, 0, 1, 0, 2'd0, 0, 1, 8'h10, 8'd3, 1, 8'h11);
    tv[13] = mk(0, 8'h00, 1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[14] = mk(0, 8'h00, 1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[15] = mk(1, 8'hA5, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[16] = mk(1, 8'h20, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[17] = mk(1, 8'h02, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[18] = mk(1, 8'hAA, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[19] = mk(1, 8'hBB, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[20] = mk(1, 8'h00, 0, 0, 0, 1, 2'd1, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[21] = mk(0, 8'h00, 0, 0, 0, 0, 2'd1, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[22] = mk(1, 8'hA5, 0, 0, 0, 0, 2'd1, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[23] = mk(1, 8'h30, 0, 0, 0, 0, 2'd1, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[24] = mk(1, 8'h00, 0, 0, 0, 0, 2'd1, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[25] = mk(1, 8'h30, 0, 0, 1, 0, 2'd1, 0, 1, 8'h30, 8'd0, 0, 8'h00);
    tv[26] = mk(1, 8'hA5, 1, 0, 0, 0, 2'd1, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[27] = mk(1, 8'h30, 0, 0, 0, 0, 2'd1, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[28] = mk(1, 8'h11, 0, 0, 0, 1, 2'd2, 0, 0, 8'h00, 8'd0, 0, 8'h00);
    tv[29] = mk(0, 8'h00, 0, 0, 0, 0, 2'd2, 0, 0, 8'h00, 8'd0, 0, 8'h00);

    // Reset values
    #12;
    chk("rst ready", 32'(frame_ready), 32'd0);
    chk("rst err_valid", 32'(err_valid), 32'd0);
    chk("rst err_code", 32'(err_code), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    chk("rst cmd", 32'(frame_cmd), 32'd0);
    chk("rst len", 32'(frame_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      rd_addr = tv[i].ra;
      apply(tv[i].vld, tv[i].b, tv[i].ack);
      chk($sformatf("v%0d ready", i), 32'(frame_ready), 32'(tv[i].e_ready));
      chk($sformatf("v%0d err_valid", i), 32'(err_valid), 32'(tv[i].e_err));
      chk($sformatf("v%0d err_code", i), 32'(err_code), 32'(tv[i].e_code));
      chk($sformatf("v%0d overrun", i), 32'(overrun), 32'(tv[i].e_ovr));
      if (tv[i].chk_fr) begin
        chk($sformatf("v%0d cmd", i), 32'(frame_cmd), 32'(tv[i].e_cmd));
        chk($sformatf("v%0d len", i), 32'(frame_len), 32'(tv[i].e_len));
      end
      if (tv[i].chk_rd) chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(tv[i].e_rd));
    end

    // Maximum-length frame with an embedded 0xA5 data byte
    x = 8'h7E ^ 8'd16;
    for (int i = 0; i < 16; i++) begin
      pl[i] = (i == 5) ? 8'hA5 : 8'(i * 7 + 1);
      x = x ^ pl[i];
    end
    apply(1, 8'hA5, 0);
    apply(1, 8'h7E, 0);
    apply(1, 8'd16, 0);
    for (int i = 0; i < 16; i++) apply(1, pl[i], 0);
    chk("max pre-chk ready", 32'(frame_ready), 32'd0);
    apply(1, x, 0);
    chk("max ready", 32'(frame_ready), 32'd1);
    chk("max err", 32'(err_valid), 32'd0);
    chk("max cmd", 32'(frame_cmd), 32'h7E);
    chk("max len", 32'(frame_len), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk($sformatf("max rd%0d", i), 32'(rd_data), 32'(pl[i]));
    end
    apply(0, 8'h00, 1);
    chk("max ack ready", 32'(frame_ready), 32'd0);

    // Timeout: exactly 50 silent clocks after the CMD byte
    apply(1, 8'hA5, 0);
    apply(1, 8'h40, 0);
    for (int k = 1; k <= 50; k++) begin
      apply(0, 8'h00, 0);
      chk($sformatf("to err k%0d", k), 32'(err_valid), (k == 50) ? 32'd1 : 32'd0);
    end
    chk("to code", 32'(err_code), 32'd3);
    apply(0, 8'h00, 0);
    chk("to strobe end", 32'(err_valid), 32'd0);

    // A byte on the 49th silent clock keeps the frame alive
    apply(1, 8'hA5, 0);
    apply(1, 8'h40, 0);
    for (int k = 1; k <= 48; k++) begin
      apply(0, 8'h00, 0);
      chk($sformatf("alive err k%0d", k), 32'(err_valid), 32'd0);
    end
    apply(1, 8'h00, 0);
    chk("alive len err", 32'(err_valid), 32'd0);
    repeat (10) apply(0, 8'h00, 0);
    apply(1, 8'h40, 0);
    chk("alive ready", 32'(frame_ready), 32'd1);
    chk("alive cmd", 32'(frame_cmd), 32'h40);
    chk("alive len", 32'(frame_len), 32'd0);
    chk("alive code", 32'(err_code), 32'd3);
    apply(0, 8'h00, 1);

    // Asynchronous reset during PAYLOAD
    apply(1, 8'hA5, 0);
    apply(1, 8'h50, 0);
    apply(1, 8'h04, 0);
    apply(1, 8'h01, 0);
    apply(1, 8'h02, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst ready", 32'(frame_ready), 32'd0);
    chk("arst err_code", 32'(err_code), 32'd0);
    chk("arst cmd", 32'(frame_cmd), 32'd0);
    chk("arst len", 32'(frame_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 8'hA5, 0);
    chk("prst err0", 32'(err_valid), 32'd0);
    apply(1, 8'h60, 0);
    chk("prst err1", 32'(err_valid), 32'd0);
    apply(1, 8'h01, 0);
    chk("prst err2", 32'(err_valid), 32'd0);
    apply(1, 8'h77, 0);
    chk("prst err3", 32'(err_valid), 32'd0);
    apply(1, 8'h16, 0);
    chk("prst ready", 32'(frame_ready), 32'd1);
    chk("prst err4", 32'(err_valid), 32'd0);
    chk("prst cmd", 32'(frame_cmd), 32'h60);
    chk("prst len", 32'(frame_len), 32'd1);
    rd_addr = 4'd0;
    #1;
    chk("prst rd0", 32'(rd_data), 32'h77);
    apply(0, 8'h00, 0);
    chk("prst err5", 32'(err_valid), 32'd0);
    chk("prst code", 32'(err_code), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
